// File: rtl/glitch_sweep_pkg.sv
// Shared types for the glitch parameter-sweep sequencer.
// Holds the FSM encoding and the repeat-count helper.
package glitch_sweep_pkg;

    typedef enum logic [2:0] {
        SW_IDLE      = 3'd0,
        SW_ARM       = 3'd1,
        SW_FIRE      = 3'd2,
        SW_WAIT_DONE = 3'd3,
        SW_COOL      = 3'd4,
        SW_ADVANCE   = 3'd5
    } sw_state_t;

    // A repeat count of zero still fires once per grid point.
    function automatic logic [7:0] rep_max(input logic [7:0] r);
        return (r == 8'd0) ? 8'd1 : r;
    endfunction

endpackage

// File: rtl/glitch_sweep_axis.sv
// One sweep axis: latches its range on load and steps through it.
// Wraps back to start on zero step, carry out, or passing the end value.
module glitch_sweep_axis #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step_en,
    input  logic [W-1:0] start_val,
    input  logic [W-1:0] end_val,
    input  logic [W-1:0] step_val,
    output logic [W-1:0] cur,
    output logic         wrap
);

    logic [W-1:0] start_q;
    logic [W-1:0] end_q;
    logic [W-1:0] step_q;
    logic [W:0]   nxt;

    assign nxt  = {1'b0, cur} + {1'b0, step_q};
    assign wrap = (step_q == '0) | nxt[W] | (nxt[W-1:0] > end_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= '0;
            start_q <= '0;
            end_q   <= '0;
            step_q  <= '0;
        end else if (load) begin
            cur     <= start_val;
            start_q <= start_val;
            end_q   <= end_val;
            step_q  <= step_val;
        end else if (step_en) begin
            cur <= wrap ? start_q : nxt[W-1:0];
        end
    end

endmodule

// File: rtl/glitch_sweep.sv
// Walks a delay x width grid, firing the glitch block per point.
// Supports repeats, trigger alignment, cooldown and abort.
module glitch_sweep
    import glitch_sweep_pkg::*;
#(
    parameter int COOLDOWN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  use_trig,
    input  logic                  trig_in,
    input  logic [15:0]           delay_start,
    input  logic [15:0]           delay_end,
    input  logic [15:0]           delay_step,
    input  logic [7:0]            width_start,
    input  logic [7:0]            width_end,
    input  logic [7:0]            width_step,
    input  logic [7:0]            mode_cfg,
    input  logic [7:0]            repeat_cnt,
    input  logic [COOLDOWN_W-1:0] cooldown,
    output logic [15:0]           g_delay,
    output logic [7:0]            g_width,
    output logic [7:0]            g_mode,
    output logic                  g_en,
    input  logic                  g_ready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           attempts
);

    sw_state_t state;
    sw_state_t state_nxt;

    logic                  t_s1;
    logic                  t_s2;
    logic                  t_d;
    logic                  trig_edge;
    logic                  sh_use_trig;
    logic [7:0]            sh_rep;
    logic [COOLDOWN_W-1:0] sh_cool;
    logic [7:0]            rep;
    logic [COOLDOWN_W-1:0] cnt;
    logic                  accept;
    logic                  w_step;
    logic                  d_step;
    logic                  w_wrap;
    logic                  d_wrap;
    logic                  last_rep;
    logic                  cool_load;

    assign trig_edge = t_s2 & ~t_d;
    assign last_rep  = ({1'b0, rep} + 9'd1) >= {1'b0, rep_max(sh_rep)};
    assign busy      = (state != SW_IDLE);

    glitch_sweep_axis #(.W(16)) u_delay (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step_en   (d_step),
        .start_val (delay_start),
        .end_val   (delay_end),
        .step_val  (delay_step),
        .cur       (g_delay),
        .wrap      (d_wrap)
    );

    glitch_sweep_axis #(.W(8)) u_width (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step_en   (w_step),
        .start_val (width_start),
        .end_val   (width_end),
        .step_val  (width_step),
        .cur       (g_width),
        .wrap      (w_wrap)
    );

    // Abort wins over every other event, including start and trigger.
    always_comb begin
        state_nxt = state;
        g_en      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        w_step    = 1'b0;
        d_step    = 1'b0;
        cool_load = 1'b0;
        if (abort) begin
            state_nxt = SW_IDLE;
        end else begin
            unique case (state)
                SW_IDLE: begin
                    if (start && g_ready) begin
                        accept    = 1'b1;
                        state_nxt = SW_ARM;
                    end
                end
                SW_ARM: begin
                    if (!sh_use_trig || trig_edge) begin
                        state_nxt = SW_FIRE;
                    end
                end
                SW_FIRE: begin
                    if (g_ready) begin
                        g_en      = 1'b1;
                        state_nxt = SW_WAIT_DONE;
                    end
                end
                SW_WAIT_DONE: begin
                    if (g_ready) begin
                        cool_load = 1'b1;
                        state_nxt = SW_COOL;
                    end
                end
                SW_COOL: begin
                    if (cnt <= COOLDOWN_W'(1)) begin
                        state_nxt = SW_ADVANCE;
                    end
                end
                SW_ADVANCE: begin
                    state_nxt = SW_ARM;
                    if (last_rep) begin
                        w_step = 1'b1;
                        if (w_wrap) begin
                            d_step = 1'b1;
                            if (d_wrap) begin
                                done      = 1'b1;
                                state_nxt = SW_IDLE;
                            end
                        end
                    end
                end
                default: state_nxt = SW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SW_IDLE;
            t_s1        <= 1'b0;
            t_s2        <= 1'b0;
            t_d         <= 1'b0;
            sh_use_trig <= 1'b0;
            sh_rep      <= 8'd0;
            sh_cool     <= '0;
            g_mode      <= 8'd0;
            rep         <= 8'd0;
            cnt         <= '0;
            attempts    <= 32'd0;
        end else begin
            state <= state_nxt;
            t_s1  <= trig_in;
            t_s2  <= t_s1;
            t_d   <= t_s2;
            if (accept) begin
                sh_use_trig <= use_trig;
                sh_rep      <= repeat_cnt;
                sh_cool     <= cooldown;
                g_mode      <= mode_cfg;
                rep         <= 8'd0;
                attempts    <= 32'd0;
            end
            if (g_en && attempts != 32'hFFFF_FFFF) begin
                attempts <= attempts + 32'd1;
            end
            if (cool_load) begin
                cnt <= sh_cool;
            end else if (state == SW_COOL && cnt != '0) begin
                cnt <= cnt - COOLDOWN_W'(1);
            end
            if (state == SW_ADVANCE && !abort) begin
                rep <= last_rep ? 8'd0 : rep + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep.sv
// Self-checking bench for glitch_sweep with a behavioural glitch stand-in.
// Expected fire order comes from a nested-loop grid model.
module tb_glitch_sweep;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          use_trig = 1'b0;
    logic          trig_in = 1'b0;
    logic [15:0]   delay_start = 16'd0;
    logic [15:0]   delay_end = 16'd0;
    logic [15:0]   delay_step = 16'd0;
    logic [7:0]    width_start = 8'd0;
    logic [7:0]    width_end = 8'd0;
    logic [7:0]    width_step = 8'd0;
    logic [7:0]    mode_cfg = 8'd0;
    logic [7:0]    repeat_cnt = 8'd0;
    logic [CW-1:0] cooldown = '0;
    logic [15:0]   g_delay;
    logic [7:0]    g_width;
    logic [7:0]    g_mode;
    logic          g_en;
    logic          g_ready;
    logic          busy;
    logic          done;
    logic [31:0]   attempts;

    glitch_sweep #(.COOLDOWN_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .use_trig    (use_trig),
        .trig_in     (trig_in),
        .delay_start (delay_start),
        .delay_end   (delay_end),
        .delay_step  (delay_step),
        .width_start (width_start),
        .width_end   (width_end),
        .width_step  (width_step),
        .mode_cfg    (mode_cfg),
        .repeat_cnt  (repeat_cnt),
        .cooldown    (cooldown),
        .g_delay     (g_delay),
        .g_width     (g_width),
        .g_mode      (g_mode),
        .g_en        (g_en),
        .g_ready     (g_ready),
        .busy        (busy),
        .done        (done),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Glitch stand-in: busy for a run length derived from delay+width.
    function automatic int run_len(input logic [15:0] d, input logic [7:0] w);
        return ((int'(d) + int'(w)) % 16) + 2;
    endfunction

    int gcnt = 0;
    always @(posedge clk) begin
        if (g_en) gcnt <= run_len(g_delay, g_width);
        else if (gcnt > 0) gcnt <= gcnt - 1;
    end
    assign g_ready = (gcnt == 0);

    typedef struct {
        logic [15:0] d;
        logic [7:0]  w;
    } pt_t;

    pt_t        exp_q[$];
    logic [7:0] exp_mode = 8'd0;
    int errors = 0;
    int checks = 0;
    int n_fired = 0;
    int done_cnt = 0;
    int first_en_cyc = 0;
    int last_en_cyc = 0;
    int last_rise_cyc = 0;
    int min_gap = 1000000;
    bit prev_ready = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input longint act,
                             input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Grid model: outer delay loop, inner width loop, repeats per point.
    task automatic build_model();
        int  d, w, nd, nw, r;
        bit  dmore, wmore;
        pt_t p;
        exp_q.delete();
        exp_mode = mode_cfg;
        r = (repeat_cnt == 0) ? 1 : int'(repeat_cnt);
        d = int'(delay_start);
        do begin
            w = int'(width_start);
            do begin
                for (int k = 0; k < r; k++) begin
                    p.d = 16'(d);
                    p.w = 8'(w);
                    exp_q.push_back(p);
                end
                nw = w + int'(width_step);
                wmore = (width_step != 0) && (nw <= int'(width_end)) && (nw <= 255);
                w = nw;
            end while (wmore);
            nd = d + int'(delay_step);
            dmore = (delay_step != 0) && (nd <= int'(delay_end)) && (nd <= 65535);
            d = nd;
        end while (dmore);
    endtask

    task automatic compare_cycle();
        pt_t e;
        if (g_en) begin
            if (exp_q.size() == 0) begin
                chk("g_en_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("g_delay", g_delay, e.d);
                chk("g_width", g_width, e.w);
                chk("g_mode", g_mode, exp_mode);
                chk("attempts_at_fire", attempts, n_fired);
                chk("fire_while_ready", g_ready, 1);
            end
            if (n_fired == 0) first_en_cyc = cyc;
            else if (cyc - last_rise_cyc < min_gap) min_gap = cyc - last_rise_cyc;
            last_en_cyc = cyc;
            n_fired++;
        end
        if (done) begin
            done_cnt++;
            chk("done_drained", exp_q.size(), 0);
        end
        if (g_ready && !prev_ready) last_rise_cyc = cyc;
        prev_ready = g_ready;
    endtask

    task automatic wait_fired(input int n, input int budget, input string nm);
        int t = 0;
        while (n_fired < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk(nm, n_fired >= n, 1);
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(negedge clk);
            t++;
            if (toggle && (t % 9) == 0) trig_in = ~trig_in;
        end
        chk("done_within_budget", done_cnt != 0, 1);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(output int s);
        int n;
        build_model();
        n = exp_q.size();
        n_fired = 0;
        done_cnt = 0;
        min_gap = 1000000;
        pulse_start(s);
        wait_done(n * 200 + 300, use_trig);
        @(negedge clk);
        chk("attempts_final", attempts, n);
        chk("done_once", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("fired_count", n_fired, n);
    endtask

    task automatic set_grid(input int ds, input int de, input int dst,
                            input int ws, input int we, input int wst,
                            input int rp, input int cl);
        delay_start = 16'(ds);
        delay_end   = 16'(de);
        delay_step  = 16'(dst);
        width_start = 8'(ws);
        width_end   = 8'(we);
        width_step  = 8'(wst);
        repeat_cnt  = 8'(rp);
        cooldown    = CW'(cl);
    endtask

    task automatic main_seq();
        int s, e, att;
        repeat (3) @(negedge clk);
        chk("rst_g_delay", g_delay, 0);
        chk("rst_g_width", g_width, 0);
        chk("rst_g_mode", g_mode, 0);
        chk("rst_g_en", g_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_attempts", attempts, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic grid, also pins the model against hand-derived points.
        set_grid(10, 30, 10, 2, 4, 2, 1, 0);
        mode_cfg = 8'hA5;
        build_model();
        chk("model_basic_n", exp_q.size(), 6);
        chk("model_p0_d", exp_q[0].d, 10);
        chk("model_p1_w", exp_q[1].w, 4);
        chk("model_p3_d", exp_q[3].d, 20);
        chk("model_p5_d", exp_q[5].d, 30);
        chk("model_p5_w", exp_q[5].w, 4);
        run_sweep(s);
        chk("start_to_g_en", first_en_cyc - s, 2);
        chk("basic_attempts_lit", attempts, 6);

        // Repeats with cooldown.
        set_grid(5, 5, 1, 1, 1, 1, 3, 8);
        mode_cfg = 8'h3C;
        run_sweep(s);
        chk("repeat_attempts_lit", attempts, 3);
        chk_range("cooldown_gap", min_gap, 8, 1000000);

        // Trigger gating.
        set_grid(4, 4, 0, 1, 2, 1, 1, 0);
        use_trig = 1'b1;
        trig_in = 1'b0;
        build_model();
        n_fired = 0;
        done_cnt = 0;
        pulse_start(s);
        repeat (100) @(negedge clk);
        chk("trig_no_fire", n_fired, 0);
        chk("trig_busy", busy, 1);
        @(negedge clk);
        e = cyc;
        trig_in = 1'b1;
        wait_fired(1, 10, "trig1_fired");
        chk_range("trig1_latency", first_en_cyc - e, 3, 4);
        trig_in = 1'b0;
        @(negedge clk);
        trig_in = 1'b1;
        repeat (30) @(negedge clk);
        chk("trig_no_extra", n_fired, 1);
        trig_in = 1'b0;
        repeat (3) @(negedge clk);
        e = cyc;
        trig_in = 1'b1;
        wait_fired(2, 10, "trig2_fired");
        chk_range("trig2_latency", last_en_cyc - e, 3, 4);
        wait_done(200, 1'b0);
        @(negedge clk);
        chk("trig_attempts", attempts, 2);
        use_trig = 1'b0;
        trig_in = 1'b0;

        // Degenerate axes.
        set_grid(16'hFFF0, 16'hFFFF, 16'h20, 3, 9, 0, 1, 0);
        build_model();
        chk("model_ovf_n", exp_q.size(), 1);
        run_sweep(s);
        chk("ovf_attempts_lit", attempts, 1);
        set_grid(50, 20, 5, 2, 2, 1, 1, 0);
        build_model();
        chk("model_rev_n", exp_q.size(), 1);
        run_sweep(s);
        chk("rev_attempts_lit", attempts, 1);

        // Abort while the glitch is still running.
        set_grid(40, 60, 20, 1, 1, 0, 1, 0);
        build_model();
        n_fired = 0;
        done_cnt = 0;
        pulse_start(s);
        wait_fired(1, 20, "abort_fired");
        chk("abort_glitch_running", g_ready, 0);
        att = int'(attempts);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_attempts_hold", attempts, att);
        exp_q.delete();
        pulse_start(s);
        chk("start_blocked_busy", busy, 0);
        chk("start_blocked_attempts", attempts, att);
        for (int t = 0; t < 40 && !g_ready; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        set_grid(7, 9, 2, 0, 3, 3, 2, 1);
        run_sweep(s);

        // Randomized sweeps, some trigger-gated.
        for (int i = 0; i < 6; i++) begin
            set_grid($urandom_range(30), $urandom_range(40),
                     ($urandom_range(4) == 0) ? 0 : $urandom_range(9, 4),
                     $urandom_range(6), $urandom_range(8),
                     ($urandom_range(4) == 0) ? 0 : $urandom_range(4, 2),
                     $urandom_range(2), $urandom_range(3));
            mode_cfg = 8'($urandom);
            use_trig = 1'($urandom_range(1));
            run_sweep(s);
            trig_in = 1'b0;
            use_trig = 1'b0;
        end

        // Async reset during cooldown.
        set_grid(3, 3, 0, 1, 1, 0, 1, 20);
        build_model();
        n_fired = 0;
        done_cnt = 0;
        pulse_start(s);
        wait_fired(1, 20, "rst_fired");
        repeat (12) @(negedge clk);
        chk("rst_in_cool_busy", busy, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_g_delay", g_delay, 0);
        chk("arst_g_width", g_width, 0);
        chk("arst_g_mode", g_mode, 0);
        chk("arst_g_en", g_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_attempts", attempts, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            begin : cmp
                forever begin
                    @(negedge clk);
                    if (!rst) compare_cycle();
                end
            end
            main_seq();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
